// File: rtl/cell_row_reader_pkg.sv
// rtl/cell_row_reader_pkg.sv - shared text-cell constants and row fetch types
package cell_row_reader_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Physical row pitch in cells; only COLUMNS of them are visible.
    localparam int REAL_WIDTH = 128;

    // Cell layout: {background, foreground, attributes, character}.
    localparam logic [7:0] SPACE_CHARACTER = 8'h20;
    localparam logic [7:0] DEFAULT_BG      = 8'h00;
    localparam logic [7:0] DEFAULT_FG      = 8'h07;
    localparam logic [7:0] DEFAULT_ATTR    = 8'h00;

    localparam logic [31:0] BLANK_CELL = {DEFAULT_BG, DEFAULT_FG, DEFAULT_ATTR, SPACE_CHARACTER};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_RECEIVE,
        ST_BLANK
    } fetch_state_t;

    // A cell holding the given character with default colours and no attributes.
    function automatic logic [31:0] clear_cell(input logic [7:0] ch);
        return {DEFAULT_BG, DEFAULT_FG, DEFAULT_ATTR, ch};
    endfunction

    // Byte address of column 0 of a text row: row * REAL_WIDTH cells * 4 bytes.
    function automatic logic [22:0] row_address(input logic [5:0] row);
        return {8'b0, row, 7'b0, 2'b00};
    endfunction

endpackage

// File: rtl/cell_row_reader_ram.sv
// rtl/cell_row_reader_ram.sv - simple dual-port line RAM with registered read
module cell_line_ram #(
    parameter int DEPTH = 160,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, cleared by reset; array contents are kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cell_row_reader.sv
// rtl/cell_row_reader.sv - fetches one text row from SDRAM into a double-buffered line store
module cell_row_reader #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 51
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [5:0]  fetch_row,
    output logic        busy,
    input  logic        swap,
    output logic        underrun,
    input  logic [6:0]  cell_col,
    output logic [31:0] cell_data,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done
);

    import cell_row_reader_pkg::*;

    localparam int         AW        = $clog2(2 * COLUMNS);
    localparam logic [6:0] COL_LIMIT = 7'(COLUMNS);
    localparam logic [6:0] LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [6:0] ROW_LIMIT = 7'(ROWS);

    fetch_state_t state;
    logic [6:0]   counter;
    logic         front_sel;
    logic         back_ready;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW-1:0] front_base;
    logic [AW-1:0] back_base;
    logic          col_oob;
    logic          col_oob_q;
    logic [6:0]    rd_col;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_rdata;

    assign rd_burst_length = 9'(COLUMNS);

    // Buffer 0 lives at RAM words [0, COLUMNS), buffer 1 at [COLUMNS, 2*COLUMNS).
    assign front_base = front_sel ? AW'(COLUMNS) : '0;
    assign back_base  = front_sel ? '0 : AW'(COLUMNS);

    // Fetch/swap control: swap is evaluated against the pre-edge state so a
    // same-cycle fetch_start fills the buffer that just became the back one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_request <= FALSE;
            rd_address <= '0;
            busy       <= FALSE;
            underrun   <= FALSE;
            counter    <= '0;
            front_sel  <= FALSE;
            back_ready <= FALSE;
        end else begin
            underrun <= FALSE;
            if (swap) begin
                if (state == ST_IDLE && back_ready) begin
                    front_sel  <= ~front_sel;
                    back_ready <= FALSE;
                end else begin
                    underrun <= TRUE;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        back_ready <= FALSE;
                        counter    <= '0;
                        busy       <= TRUE;
                        if ({1'b0, fetch_row} < ROW_LIMIT) begin
                            rd_address <= row_address(fetch_row);
                            rd_request <= TRUE;
                            state      <= ST_REQUEST;
                        end else begin
                            state <= ST_BLANK;
                        end
                    end
                end
                ST_REQUEST, ST_RECEIVE: begin
                    if (rd_data_valid) begin
                        rd_request <= FALSE;
                        state      <= ST_RECEIVE;
                        if (counter < COL_LIMIT) begin
                            counter <= counter + 7'd1;
                        end
                    end
                    if (rd_done) begin
                        rd_request <= FALSE;
                        busy       <= FALSE;
                        back_ready <= TRUE;
                        state      <= ST_IDLE;
                    end
                end
                ST_BLANK: begin
                    counter <= counter + 7'd1;
                    if (counter == LAST_COL) begin
                        busy       <= FALSE;
                        back_ready <= TRUE;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Back-buffer write decode: SDRAM words while fetching, blanks while clearing.
    always_comb begin
        wr_en   = FALSE;
        wr_data = rd_data;
        case (state)
            ST_REQUEST, ST_RECEIVE: wr_en = rd_data_valid && (counter < COL_LIMIT);
            ST_BLANK: begin
                wr_en   = TRUE;
                wr_data = BLANK_CELL;
            end
            default: wr_en = FALSE;
        endcase
        if (reset) begin
            wr_en = FALSE;
        end
        wr_addr = back_base + AW'(counter);
    end

    // Columns past the visible width read as blank; clamp the address so the RAM is never indexed out of range.
    assign col_oob   = cell_col >= COL_LIMIT;
    assign rd_col    = col_oob ? 7'd0 : cell_col;
    assign ram_raddr = front_base + AW'(rd_col);

    // Track the out-of-range flag alongside the RAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_oob_q <= FALSE;
        end else begin
            col_oob_q <= col_oob;
        end
    end

    assign cell_data = col_oob_q ? BLANK_CELL : ram_rdata;

    cell_line_ram #(
        .DEPTH (2 * COLUMNS),
        .AW    (AW),
        .DW    (32)
    ) u_line_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_cell_row_reader.sv
// tb/tb_cell_row_reader.sv - randomized self-checking bench for cell_row_reader
module tb_cell_row_reader;

    localparam int          COLS      = 80;
    localparam int          NROWS     = 51;
    localparam logic [31:0] EXP_BLANK = 32'h0007_0020;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic [5:0]  fetch_row;
    logic        busy;
    logic        swap;
    logic        underrun;
    logic [6:0]  cell_col;
    logic [31:0] cell_data;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [8:0]  rd_burst_length;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;

    cell_row_reader #(.COLUMNS(COLS), .ROWS(NROWS)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_start     (fetch_start),
        .fetch_row       (fetch_row),
        .busy            (busy),
        .swap            (swap),
        .underrun        (underrun),
        .cell_col        (cell_col),
        .cell_data       (cell_data),
        .rd_address      (rd_address),
        .rd_request      (rd_request),
        .rd_burst_length (rd_burst_length),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .rd_done         (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: two physical line buffers, which one is displayed, and whether the back one is complete.
    logic [31:0] mbuf [2][COLS];
    int          mfront      = 0;
    bit          mready      = 0;
    bit          cells_known = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_swap(input bit expect_ok);
        int c;
        logic [31:0] old_v, new_v;
        c = $urandom_range(0, COLS - 1);
        cell_col = 7'(c);
        tick();
        old_v = mbuf[mfront][c];
        new_v = expect_ok ? mbuf[1 - mfront][c] : old_v;
        if (cells_known) check("pre_swap_cell", cell_data, old_v);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check("swap_underrun", underrun, 32'(!expect_ok));
        if (cells_known) check("swap_cell_same_cycle", cell_data, old_v);
        if (expect_ok) begin
            mfront = 1 - mfront;
            mready = 0;
        end
        tick();
        check("underrun_width", underrun, 0);
        if (cells_known) check("swap_cell_next", cell_data, new_v);
    endtask

    task automatic do_fetch(input logic [5:0] row, input int nwords, input bit with_swap, input bit seq_words);
        logic [31:0] words [$];
        logic [22:0] exp_addr;
        bit          done_with_last;
        words.delete();
        for (int i = 0; i < nwords; i++) words.push_back(seq_words ? 32'h100 + 32'(i) : $urandom);
        exp_addr = 23'(row) << 9;
        fetch_row   = row;
        fetch_start = 1'b1;
        swap        = with_swap;
        tick();
        fetch_start = 1'b0;
        swap        = 1'b0;
        if (with_swap) begin
            check("swapfetch_underrun", underrun, 32'(!mready));
            if (mready) mfront = 1 - mfront;
        end
        mready = 0;
        check("req_busy", busy, 1);
        check("req_rd_request", rd_request, 1);
        check("req_address", rd_address, exp_addr);
        check("req_burst_length", rd_burst_length, COLS);
        repeat ($urandom_range(0, 3)) tick();
        done_with_last = $urandom_range(0, 1) == 1;
        for (int i = 0; i < nwords; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            rd_data_valid = 1'b1;
            rd_data       = words[i];
            rd_done       = (i == nwords - 1) && done_with_last;
            tick();
            rd_data_valid = 1'b0;
            rd_done       = 1'b0;
            if (i == 0) check("req_drop_after_first", rd_request, 0);
        end
        if (!done_with_last) begin
            rd_done = 1'b1;
            tick();
            rd_done = 1'b0;
        end
        check("fetch_done_busy", busy, 0);
        for (int i = 0; i < nwords && i < COLS; i++) mbuf[1 - mfront][i] = words[i];
        mready = 1;
    endtask

    task automatic do_blank(input logic [5:0] row, input bit swap_mid);
        int cnt;
        bit req_seen;
        fetch_row   = row;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mready   = 0;
        cnt      = 0;
        req_seen = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (rd_request) req_seen = 1;
            if (swap_mid && cnt == 10) swap = 1'b1;
            tick();
            swap = 1'b0;
            if (swap_mid && cnt == 10) check("busy_swap_underrun", underrun, 1);
            if (swap_mid && cnt == 11) check("busy_underrun_width", underrun, 0);
        end
        check("blank_busy_cycles", cnt, COLS);
        check("blank_no_request", 32'(req_seen), 0);
        for (int i = 0; i < COLS; i++) mbuf[1 - mfront][i] = EXP_BLANK;
        mready = 1;
    endtask

    task automatic check_front(input string tag, input int n);
        int c;
        int total;
        total = (n == 0) ? COLS + 2 : n;
        for (int k = 0; k < total; k++) begin
            if (n == 0) c = (k < COLS) ? k : ((k == COLS) ? COLS : 127);
            else        c = ($urandom_range(0, 4) == 0) ? $urandom_range(COLS, 127) : $urandom_range(0, COLS - 1);
            cell_col = 7'(c);
            tick();
            check(tag, cell_data, (c < COLS) ? mbuf[mfront][c] : EXP_BLANK);
        end
    endtask

    task automatic stray_idle();
        for (int k = 0; k < 4; k++) begin
            rd_data_valid = 1'($urandom_range(0, 1));
            rd_done       = 1'($urandom_range(0, 1));
            rd_data       = $urandom;
            tick();
            check("stray_busy", busy, 0);
        end
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
    endtask

    task automatic reset_mid_burst();
        fetch_row   = 6'd7;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_data_valid = 1'b1;
            rd_data       = $urandom;
            mbuf[1 - mfront][i] = rd_data;
            tick();
        end
        rd_data_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_mid_rd_request", rd_request, 0);
        check("rst_mid_busy", busy, 0);
        reset  = 1'b0;
        mfront = 0;
        mready = 0;
        for (int i = 10; i < COLS; i++) begin
            rd_data_valid = 1'b1;
            rd_data       = $urandom;
            rd_done       = (i == COLS - 1);
            tick();
        end
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
        check("rst_stray_busy", busy, 0);
        check("rst_stray_request", rd_request, 0);
    endtask

    initial begin
        reset         = 1'b1;
        fetch_start   = 1'b0;
        fetch_row     = '0;
        swap          = 1'b0;
        cell_col      = '0;
        rd_data       = '0;
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
        repeat (3) tick();
        check("rst_rd_request", rd_request, 0);
        check("rst_rd_address", rd_address, 0);
        check("rst_burst_length", rd_burst_length, COLS);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_cell_data", cell_data, 0);
        reset = 1'b0;
        tick();

        // Fill both physical buffers with blanks so every later cell comparison is known.
        do_blank(6'd51, 1'b1);
        do_swap(1'b1);
        do_blank(6'd63, 1'b0);
        cells_known = 1;
        check_front("blank_front", 0);
        do_swap(1'b1);
        check_front("blank_front2", 0);

        // Row 3 with words 0x100+i.
        do_fetch(6'd3, COLS, 1'b0, 1'b1);
        do_swap(1'b1);
        cell_col = 7'd5;
        tick();
        check("row3_col5", cell_data, 32'h105);
        do_swap(1'b0);

        // Over-long burst.
        do_fetch(6'd10, COLS + 2, 1'b0, 1'b0);
        do_swap(1'b1);
        check_front("overlong_front", 0);

        // Swap and fetch in the same cycle.
        do_fetch(6'd20, COLS, 1'b0, 1'b0);
        do_fetch(6'd21, COLS, 1'b1, 1'b0);
        check_front("swapfetch_front", 0);
        do_swap(1'b1);
        check_front("swapfetch_after", 0);

        stray_idle();
        reset_mid_burst();
        do_swap(1'b0);
        do_fetch(6'd0, COLS, 1'b0, 1'b0);
        do_swap(1'b1);
        check_front("post_reset_front", 0);

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 4))
                0: do_fetch(6'($urandom_range(0, NROWS - 1)), $urandom_range(COLS - 3, COLS + 3),
                            1'($urandom_range(0, 1)), 1'b0);
                1: do_blank(6'($urandom_range(NROWS, 63)), 1'($urandom_range(0, 1)));
                2: do_swap(mready);
                3: check_front("rand_front", 6);
                default: stray_idle();
            endcase
        end
        check_front("final_front", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
